// File: rtl/bcd_chain_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bcd_chain_pkg : shared widths and terminal-count helper for the BCD chain  |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
package bcd_chain_pkg;

    localparam int DIGIT_W = 4;

    // A digit is terminal at its maximum when counting up, at zero when counting down.
    function automatic logic digit_is_terminal(
        input logic [DIGIT_W-1:0] d,
        input logic [DIGIT_W-1:0] max_d,
        input logic               up
    );
        return up ? (d == max_d) : (d == '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_chain_counter_digit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bcd_digit_cell : one modulo-RADIX digit with clear, clamped load and step  |
// | Revision       : 1.0                                                       |
// +----------------------------------------------------------------------------+
module bcd_digit_cell
    import bcd_chain_pkg::*;
#(
    parameter int RADIX = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               step_in,
    input  logic               up,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_digit,
    input  logic               clear,
    output logic [DIGIT_W-1:0] digit,
    output logic [DIGIT_W-1:0] digit_nxt,
    output logic               at_max,
    output logic               at_min
);

    localparam logic [DIGIT_W-1:0] C_MAX = DIGIT_W'(RADIX - 1);

    logic [DIGIT_W-1:0] r_digit_q;
    logic [DIGIT_W-1:0] w_digit_d;

    always_comb begin
        w_digit_d = r_digit_q;
        if (clear) begin
            w_digit_d = '0;
        end else if (load) begin
            w_digit_d = (load_digit > C_MAX) ? C_MAX : load_digit;
        end else if (step_in) begin
            // Out-of-range codes are treated as maximum so they always return to 0.
            if (up) begin
                w_digit_d = (r_digit_q >= C_MAX) ? '0 : r_digit_q + DIGIT_W'(1);
            end else begin
                w_digit_d = (r_digit_q == '0) ? C_MAX : r_digit_q - DIGIT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_digit_q <= '0;
        end else begin
            r_digit_q <= w_digit_d;
        end
    end

    assign digit     = r_digit_q;
    assign digit_nxt = w_digit_d;
    assign at_max    = (r_digit_q == C_MAX);
    assign at_min    = (r_digit_q == '0);

endmodule
`default_nettype wire

// File: rtl/bcd_chain_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bcd_chain_counter : cascadable multi-digit up/down modulo-RADIX counter    |
// | Revision          : 1.0                                                    |
// +----------------------------------------------------------------------------+
module bcd_chain_counter
    import bcd_chain_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int RADIX  = 10,
    parameter int WRAP   = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      load,
    input  logic [DIGIT_W*DIGITS-1:0] load_val,
    input  logic                      en,
    input  logic                      up,
    output logic [DIGIT_W*DIGITS-1:0] count,
    output logic                      co,
    output logic                      cascade_o,
    output logic                      wrap_p,
    output logic                      ovf
);

    localparam logic [DIGIT_W-1:0] C_MAX  = DIGIT_W'(RADIX - 1);
    localparam bit                 C_WRAP = (WRAP != 0);

    logic [DIGITS-1:0] w_at_max;
    logic [DIGITS-1:0] w_at_min;
    logic [DIGITS-1:0] w_step_in;
    logic [DIGITS-1:0] w_term_next_bits;
    logic [DIGIT_W*DIGITS-1:0] w_count_nxt;

    logic w_term_now;
    logic w_full_step;
    logic w_step;

    logic r_co_q,     w_co_d;
    logic r_wrap_p_q, w_wrap_p_d;
    logic r_ovf_q,    w_ovf_d;

    assign w_term_now  = up ? (&w_at_max) : (&w_at_min);
    assign w_full_step = en & ~load & ~clear & w_term_now;
    // In saturate mode a step at terminal is suppressed so every digit holds.
    assign w_step      = en & ~load & ~clear & ~(w_term_now & ~C_WRAP);

    always_comb begin
        logic carry;
        carry     = w_step;
        w_step_in = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w_step_in[i] = carry;
            carry        = carry & (up ? w_at_max[i] : w_at_min[i]);
        end
    end

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            bcd_digit_cell #(
                .RADIX (RADIX)
            ) u_cell (
                .clk        (clk),
                .rst        (rst),
                .step_in    (w_step_in[gi]),
                .up         (up),
                .load       (load),
                .load_digit (load_val[gi*DIGIT_W +: DIGIT_W]),
                .clear      (clear),
                .digit      (count[gi*DIGIT_W +: DIGIT_W]),
                .digit_nxt  (w_count_nxt[gi*DIGIT_W +: DIGIT_W]),
                .at_max     (w_at_max[gi]),
                .at_min     (w_at_min[gi])
            );
            assign w_term_next_bits[gi] =
                digit_is_terminal(w_count_nxt[gi*DIGIT_W +: DIGIT_W], C_MAX, up);
        end
    endgenerate

    always_comb begin
        w_co_d     = &w_term_next_bits;
        w_wrap_p_d = w_full_step & C_WRAP;
        w_ovf_d    = r_ovf_q | w_full_step;
        if (clear | load) begin
            w_ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_co_q     <= 1'b0;
            r_wrap_p_q <= 1'b0;
            r_ovf_q    <= 1'b0;
        end else begin
            r_co_q     <= w_co_d;
            r_wrap_p_q <= w_wrap_p_d;
            r_ovf_q    <= w_ovf_d;
        end
    end

    assign co        = r_co_q;
    assign wrap_p    = r_wrap_p_q;
    assign ovf       = r_ovf_q;
    assign cascade_o = r_co_q & en & ~load & ~clear;

endmodule
`default_nettype wire

// File: tb/tb_bcd_chain_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_bcd_chain_counter : directed vector bench for bcd_chain_counter         |
// | Revision             : 1.0                                                 |
// +----------------------------------------------------------------------------+
module tb_bcd_chain_counter;

    logic        clk = 1'b0;
    logic        rst, clear, load, en, up;
    logic [7:0]  load_val;
    logic [11:0] load_val_c;

    logic [7:0]  count_a, count_b;
    logic        co_a, cas_a, wp_a, ovf_a;
    logic        co_b, cas_b, wp_b, ovf_b;
    logic [11:0] count_c, count_d;
    logic        co_c, cas_c, wp_c, ovf_c;
    logic        co_d, cas_d, wp_d, ovf_d;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bcd_chain_counter #(.DIGITS(2), .RADIX(10), .WRAP(1)) u_a (
        .clk(clk), .rst(rst), .clear(clear), .load(load), .load_val(load_val),
        .en(en), .up(up), .count(count_a), .co(co_a), .cascade_o(cas_a),
        .wrap_p(wp_a), .ovf(ovf_a));

    bcd_chain_counter #(.DIGITS(2), .RADIX(10), .WRAP(0)) u_b (
        .clk(clk), .rst(rst), .clear(clear), .load(load), .load_val(load_val),
        .en(en), .up(up), .count(count_b), .co(co_b), .cascade_o(cas_b),
        .wrap_p(wp_b), .ovf(ovf_b));

    bcd_chain_counter #(.DIGITS(3), .RADIX(6), .WRAP(1)) u_c (
        .clk(clk), .rst(rst), .clear(clear), .load(load), .load_val(load_val_c),
        .en(en), .up(up), .count(count_c), .co(co_c), .cascade_o(cas_c),
        .wrap_p(wp_c), .ovf(ovf_c));

    bcd_chain_counter #(.DIGITS(3), .RADIX(6), .WRAP(1)) u_d (
        .clk(clk), .rst(rst), .clear(clear), .load(load), .load_val(load_val_c),
        .en(cas_c), .up(up), .count(count_d), .co(co_d), .cascade_o(cas_d),
        .wrap_p(wp_d), .ovf(ovf_d));

    typedef struct {
        logic       clr;
        logic       ld;
        logic [7:0] lv;
        logic       en;
        logic       up;
        logic [7:0] cnt;
        logic       co;
        logic       wp;
        logic       ov;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] bcd2(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic chk_a(input string nm, input logic [7:0] c, input logic o,
                         input logic w, input logic v);
        chk({nm, ".count"},  {4'h0, count_a}, {4'h0, c});
        chk({nm, ".co"},     {11'h0, co_a},   {11'h0, o});
        chk({nm, ".wrap_p"}, {11'h0, wp_a},   {11'h0, w});
        chk({nm, ".ovf"},    {11'h0, ovf_a},  {11'h0, v});
    endtask

    initial begin
        int wraps;
        int v;

        vecs[0]  = '{1'b0, 1'b1, 8'h10, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h09, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h99, 1'b0, 1'b1, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 1'b1, 8'h55, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 8'h39, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 8'h99, 1'b0, 1'b1, 8'h99, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h99, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 8'h99, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 8'h59, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h58, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 8'h09, 1'b1, 1'b1, 8'h09, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h10, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; clear = 1'b0; load = 1'b0; en = 1'b0; up = 1'b1;
        load_val = 8'h00; load_val_c = 12'h000;
        step();
        step();
        chk_a("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        chk("reset.count_c", count_c, 12'h000);
        rst = 1'b0;

        // Table-driven single-cycle vectors.
        for (int i = 0; i < 18; i++) begin
            clear = vecs[i].clr; load = vecs[i].ld; load_val = vecs[i].lv;
            en = vecs[i].en; up = vecs[i].up;
            step();
            chk_a($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].co, vecs[i].wp, vecs[i].ov);
        end
        clear = 1'b0; load = 1'b0; en = 1'b0;

        // Full up count 00..99..00.
        rst = 1'b1; step(); rst = 1'b0;
        en = 1'b1; up = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            step();
            chk_a($sformatf("up%0d", k), bcd2(k % 100), (k % 100) == 99, k == 100, k == 100);
        end

        // Down count 10..00 then 99.
        en = 1'b0; load = 1'b1; load_val = 8'h10; up = 1'b0;
        step();
        load = 1'b0; en = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            step();
            v = (k <= 10) ? 10 - k : 99;
            chk_a($sformatf("dn%0d", k), bcd2(v), v == 0, k == 11, k == 11);
        end

        // Saturating instance.
        en = 1'b0; load = 1'b1; load_val = 8'h98; up = 1'b1;
        step();
        chk("sat.load", {4'h0, count_b}, 12'h098);
        load = 1'b0; en = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk($sformatf("sat%0d.count", k), {4'h0, count_b}, 12'h099);
            chk($sformatf("sat%0d.co", k), {11'h0, co_b}, 12'h001);
            chk($sformatf("sat%0d.ovf", k), {11'h0, ovf_b}, (k >= 2) ? 12'h001 : 12'h000);
            chk($sformatf("sat%0d.wrap_p", k), {11'h0, wp_b}, 12'h000);
        end

        // Reset in the middle of counting.
        en = 1'b0; load = 1'b1; load_val = 8'h57; up = 1'b1;
        step();
        load = 1'b0; en = 1'b1; rst = 1'b1;
        step();
        chk_a("midrst", 8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        chk_a("resume", 8'h01, 1'b0, 1'b0, 1'b0);

        // Radix-6 three-digit pair chained through cascade_o.
        en = 1'b0; rst = 1'b1; step(); rst = 1'b0;
        en = 1'b1; up = 1'b1; wraps = 0;
        for (int k = 1; k <= 216; k++) begin
            step();
            if (wp_c) wraps++;
            if (k == 215) begin
                chk("casc215.low", count_c, 12'h555);
                chk("casc215.high", count_d, 12'h000);
                chk("casc215.co", {11'h0, co_c}, 12'h001);
            end
        end
        en = 1'b0;
        chk("casc.low", count_c, 12'h000);
        chk("casc.high", count_d, 12'h001);
        chk("casc.wraps", 12'(wraps), 12'h001);
        chk("casc.ovf", {11'h0, ovf_c}, 12'h001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
